// File: rtl/tlb_repl_ctrl.sv
// Tree-PLRU replacement controller for an 8-way fully-associative TLB.
// Tracks way recency from hits and latches a victim for the page-table-walker refill.
module tlb_repl_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hit_valid,
  input  logic [7:0] hit_way,
  input  logic [7:0] valid_mask,
  input  logic       refill_req,
  input  logic       refill_done,
  input  logic       flush,
  output logic       victim_valid,
  output logic [7:0] victim_way,
  output logic [2:0] victim_idx,
  output logic       busy,
  output logic [7:0] plru_state
);

  typedef enum logic [0:0] {IDLE = 1'b0, ALLOC = 1'b1} state_t;

  state_t     state_r, state_next_s;
  logic [7:0] plru_r, plru_next_s, hit_tree_s;
  logic [7:0] victim_way_r, victim_way_next_s;
  logic [2:0] victim_idx_r, victim_idx_next_s;
  logic [2:0] hit_idx_s, free_idx_s, pick_idx_s, sel_idx_s;

  // Point every node on the path to way idx away from it; bit 0 is not a node.
  function automatic logic [7:0] plru_touch(input logic [7:0] tree, input logic [2:0] idx);
    logic [7:0] t;
    t = tree;
    t[1] = ~idx[2];
    t[{2'b01, idx[2]}] = ~idx[1];
    t[{1'b1, idx[2:1]}] = ~idx[0];
    t[0] = 1'b0;
    return t;
  endfunction

  function automatic logic [2:0] plru_pick(input logic [7:0] tree);
    logic v2, v1, v0;
    v2 = tree[1];
    v1 = tree[{2'b01, v2}];
    v0 = tree[{1'b1, v2, v1}];
    return {v2, v1, v0};
  endfunction

  // OR-encoding keeps multi-hot hits well defined instead of treating them as errors.
  function automatic logic [2:0] hit_encode(input logic [7:0] way);
    logic [3:0] nib;
    logic       b2, b1, b0;
    b2  = |way[7:4];
    nib = way[7:4] | way[3:0];
    b1  = |nib[3:2];
    b0  = nib[3] | nib[1];
    return {b2, b1, b0};
  endfunction

  function automatic logic [2:0] lowest_invalid(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!mask[i]) idx = 3'(i);
      else          idx = idx;
    end
    return idx;
  endfunction

  assign hit_idx_s  = hit_encode(hit_way);
  assign free_idx_s = lowest_invalid(valid_mask);
  assign pick_idx_s = plru_pick(plru_r);
  assign sel_idx_s  = (valid_mask != 8'hFF) ? free_idx_s : pick_idx_s;
  assign hit_tree_s = hit_valid ? plru_touch(plru_r, hit_idx_s) : plru_r;

  // Next-state logic: flush wins, then hit touch followed by victim touch on refill completion.
  always_comb begin
    state_next_s      = state_r;
    plru_next_s       = hit_tree_s;
    victim_way_next_s = victim_way_r;
    victim_idx_next_s = victim_idx_r;
    if (flush) begin
      state_next_s      = IDLE;
      plru_next_s       = 8'h00;
      victim_way_next_s = 8'h00;
      victim_idx_next_s = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (refill_req) begin
            state_next_s      = ALLOC;
            victim_way_next_s = 8'h01 << sel_idx_s;
            victim_idx_next_s = sel_idx_s;
          end else begin
            state_next_s = IDLE;
          end
        end
        ALLOC: begin
          if (refill_done) begin
            state_next_s      = IDLE;
            plru_next_s       = plru_touch(hit_tree_s, victim_idx_r);
            victim_way_next_s = 8'h00;
            victim_idx_next_s = 3'd0;
          end else begin
            state_next_s = ALLOC;
          end
        end
        default: begin
          state_next_s      = IDLE;
          plru_next_s       = 8'h00;
          victim_way_next_s = 8'h00;
          victim_idx_next_s = 3'd0;
        end
      endcase
    end
  end

  // State, tree and latched victim registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      plru_r       <= 8'h00;
      victim_way_r <= 8'h00;
      victim_idx_r <= 3'd0;
    end else begin
      state_r      <= state_next_s;
      plru_r       <= plru_next_s;
      victim_way_r <= victim_way_next_s;
      victim_idx_r <= victim_idx_next_s;
    end
  end

  assign victim_valid = (state_r == ALLOC);
  assign busy         = (state_r == ALLOC);
  assign victim_way   = victim_way_r;
  assign victim_idx   = victim_idx_r;
  assign plru_state   = plru_r;

endmodule

// File: tb/tb_tlb_repl_ctrl.sv
// Scoreboard bench for tlb_repl_ctrl: a node-array PLRU model predicts every cycle,
// a monitor compares the DUT one step after each rising edge.
module tb_tlb_repl_ctrl;

  logic       clk;
  logic       rst_n;
  logic       hit_valid;
  logic [7:0] hit_way;
  logic [7:0] valid_mask;
  logic       refill_req;
  logic       refill_done;
  logic       flush;
  logic       victim_valid;
  logic [7:0] victim_way;
  logic [2:0] victim_idx;
  logic       busy;
  logic [7:0] plru_state;

  typedef struct {
    logic       vv;
    logic       bsy;
    logic [7:0] way;
    logic [2:0] idx;
    logic [7:0] plru;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: tree nodes 1..7, allocation flag and latched victim number.
  bit node[8];
  bit m_alloc;
  int m_vidx;

  tlb_repl_ctrl dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_way(hit_way),
    .valid_mask(valid_mask), .refill_req(refill_req), .refill_done(refill_done),
    .flush(flush), .victim_valid(victim_valid), .victim_way(victim_way),
    .victim_idx(victim_idx), .busy(busy), .plru_state(plru_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic int model_pick();
    int v2, v1, v0;
    v2 = node[1];
    v1 = node[2 + v2];
    v0 = node[4 + 2 * v2 + v1];
    return 4 * v2 + 2 * v1 + v0;
  endfunction

  task automatic model_touch(input int w);
    int b2, b1, b0;
    b2 = w / 4;
    b1 = (w / 2) % 2;
    b0 = w % 2;
    node[1] = (b2 == 0);
    node[2 + b2] = (b1 == 0);
    node[4 + 2 * b2 + b1] = (b0 == 0);
  endtask

  function automatic int model_hit_idx(input logic [7:0] hw);
    int hi, lo, nib, pair, b2, b1, b0;
    hi   = int'(hw) / 16;
    lo   = int'(hw) % 16;
    nib  = hi | lo;
    b2   = (hi != 0) ? 1 : 0;
    b1   = (nib / 4 != 0) ? 1 : 0;
    pair = (nib / 4) | (nib % 4);
    b0   = pair / 2;
    return 4 * b2 + 2 * b1 + b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) node[k] = 1'b0;
    m_alloc = 1'b0;
    m_vidx  = 0;
  endtask

  // Advance the model by one edge using the inputs currently driven and queue the result.
  task automatic push_expect();
    exp_t e;
    int   victim;
    bit   was_alloc;
    victim    = -1;
    was_alloc = m_alloc;
    if (flush) begin
      model_reset();
    end else begin
      if (!was_alloc && refill_req) begin
        if (valid_mask != 8'hFF) begin
          for (int i = 0; i < 8; i++)
            if (!valid_mask[i] && victim < 0) victim = i;
        end else begin
          victim = model_pick();
        end
      end
      if (hit_valid) model_touch(model_hit_idx(hit_way));
      if (!was_alloc) begin
        if (victim >= 0) begin
          m_alloc = 1'b1;
          m_vidx  = victim;
        end
      end else if (refill_done) begin
        model_touch(m_vidx);
        m_alloc = 1'b0;
      end
    end
    e.vv   = m_alloc;
    e.bsy  = m_alloc;
    e.way  = m_alloc ? (8'h01 << m_vidx) : 8'h00;
    e.idx  = m_alloc ? 3'(m_vidx) : 3'd0;
    e.plru = 8'h00;
    for (int k = 1; k < 8; k++) e.plru[k] = node[k];
    exp_q.push_back(e);
  endtask

  task automatic step(input logic hv, input logic [7:0] hw, input logic [7:0] vm,
                      input logic rq, input logic dn, input logic fl);
    @(negedge clk);
    hit_valid   = hv;
    hit_way     = hw;
    valid_mask  = vm;
    refill_req  = rq;
    refill_done = dn;
    flush       = fl;
    push_expect();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge with a pending prediction is compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("victim_valid", {7'd0, victim_valid}, {7'd0, e.vv});
      check("busy",         {7'd0, busy},         {7'd0, e.bsy});
      check("victim_way",   victim_way,           e.way);
      check("victim_idx",   {5'd0, victim_idx},   {5'd0, e.idx});
      check("plru_state",   plru_state,           e.plru);
    end
  end

  initial begin
    exp_t r;
    rst_n = 1'b0; hit_valid = 1'b0; hit_way = 8'h00; valid_mask = 8'hFF;
    refill_req = 1'b0; refill_done = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_plru", plru_state, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_way",  victim_way, 8'h00);
    rst_n = 1'b1;
    push_expect();

    // Full-valid refill from reset, then second refill.
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0); settle();
    check("first_victim", victim_way, 8'h01);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0); settle();
    check("plru_after_done", plru_state, 8'h16);
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0); settle();
    check("second_victim", victim_way, 8'h10);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Lowest invalid way beats the PLRU pick.
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'hFB, 1'b1, 1'b0, 1'b0); settle();
    check("invalid_victim", victim_way, 8'h04);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Hit on way 5 from a cleared tree, then a full-valid refill.
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h20, 8'hFF, 1'b0, 1'b0, 1'b0); settle();
    check("hit5_plru", plru_state, 8'h08);
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0); settle();
    check("hit5_victim_idx", {5'd0, victim_idx}, 8'h00);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Same-cycle hit and done: the victim touch owns the shared node.
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h02, 8'hFF, 1'b0, 1'b1, 1'b0); settle();
    check("hit_done_plru", plru_state, 8'h16);
    check("hit_done_valid", {7'd0, victim_valid}, 8'h00);

    // Flush with done in ALLOC clears everything; the next refill picks way 0.
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1); settle();
    check("flush_plru", plru_state, 8'h00);
    check("flush_way", victim_way, 8'h00);
    step(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0); settle();
    check("post_flush_victim", victim_way, 8'h01);

    // Hold refill_req in ALLOC while hits move the tree, then reset asynchronously.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h01 << $urandom_range(7), 8'hFF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {7'd0, victim_valid}, 8'h00);
    check("async_rst_way", victim_way, 8'h00);
    check("async_rst_idx", {5'd0, victim_idx}, 8'h00);
    check("async_rst_plru", plru_state, 8'h00);
    model_reset();
    r.vv = 1'b0; r.bsy = 1'b0; r.way = 8'h00; r.idx = 3'd0; r.plru = 8'h00;
    exp_q.push_back(r);
    @(negedge clk);
    hit_valid = 1'b0; refill_req = 1'b0; refill_done = 1'b0; flush = 1'b0; valid_mask = 8'hFF;
    rst_n = 1'b1;
    push_expect();
    idle(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] hw, vm;
      hw = ($urandom_range(3) == 0) ? 8'($urandom) : (8'h01 << $urandom_range(7));
      vm = ($urandom_range(9) < 7) ? 8'hFF : 8'($urandom);
      step(1'($urandom_range(1)), hw, vm, ($urandom_range(9) < 4), ($urandom_range(9) < 3),
           ($urandom_range(39) == 0));
    end
    idle(2);
    settle();
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_repl_ctrl.md
# tlb_repl_ctrl

Replacement controller for an 8-way fully-associative TLB. It holds the 7-node tree-PLRU state and updates it on every TLB hit. On a refill request it picks a victim way and latches it until the page-table walker reports that the refill is done. It sits between the TLB lookup array, which supplies hits and valid bits, and the PTW refill path, which supplies the request/done handshake and consumes the victim way.

## Interface
Parameters: none. Fixed at 8 ways and 3 tree levels.

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- hit_valid  in  1  a TLB lookup hit this cycle
- hit_way  in  8  one-hot hit way; qualified by hit_valid
- valid_mask  in  8  per-way valid bits from the TLB array
- refill_req  in  1  PTW needs a free entry (level-sensitive)
- refill_done  in  1  PTW has written the latched victim way; single-cycle pulse
- flush  in  1  TLB flush (sfence); synchronous
- victim_valid  out  1  victim_way / victim_idx are stable and owned by the refill
- victim_way  out  8  one-hot victim way
- victim_idx  out  3  binary victim index
- busy  out  1  controller is in the ALLOC state
- plru_state  out  8  tree nodes [7:1]; bit 0 is constant 0

## Operation
Tree encoding:
- Node 1 is the root.
- Nodes 2–3 are level 1, indexed 2+i2.
- Nodes 4–7 are level 2, indexed 4+{i2,i1}.

Touch of way index {b2,b1,b0}:
- Sets node1 = ~b2, node(2+b2) = ~b1, node(4+{b2,b1}) = ~b0.
- All other nodes are unchanged, so the tree points away from the touched way.

PLRU pick:
- v2 = node1, v1 = node(2+v2), v0 = node(4+{v2,v1}).

Hit encoding:
- hit_way is OR-encoded: b2 = |hit_way[7:4]; b1 = |(upper|lower nibble)[3:2]; b0 from the final pair's bit 1.
- Multi-hot input is not an error. It produces this OR-encoded index.

Victim selection:
- If valid_mask != 8'hFF, the victim is the lowest-index invalid way.
- Otherwise the victim is the PLRU pick from the current registered plru_state.

FSM with two states, IDLE and ALLOC:
- IDLE → ALLOC when refill_req=1 and flush=0. The victim is computed and latched at that edge.
- ALLOC → IDLE when refill_done=1. The latched victim is touched at that edge.
- ALLOC is held while refill_done=0. refill_req is ignored in ALLOC.
- refill_done in IDLE is ignored.
- flush in any state: next state is IDLE, plru_state=0, victim outputs are cleared. Flush takes priority over hit, refill_req and refill_done in the same cycle.

PLRU update per edge:
- Order is hit touch, then refill touch, so the victim wins where the two share a node.
- Hits in ALLOC update the tree, but the latched victim does not change.

Outputs:
- victim_valid = busy = (state==ALLOC).
- victim_way and victim_idx are registered. They are 0 in IDLE.

## Timing
- Reset values: state=IDLE, plru_state=8'h00, victim_valid=0, victim_way=8'h00, victim_idx=0, busy=0. Reset asserted mid-ALLOC abandons the refill immediately.
- Refill request latency:
  - refill_req sampled high in IDLE at edge N gives victim_valid=1 from N to N+1.
  - The victim uses plru_state and valid_mask before edge N; a same-cycle hit does not affect it.
- Refill done:
  - refill_done sampled at edge M gives victim_valid=0 and an updated plru_state after M.
  - If refill_req is still high, the earliest new victim is at edge M+1.
- Hit update: a hit is visible on plru_state one cycle after it is sampled.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, valid_mask=8'hFF, refill_req → victim_way=8'h01 and idx 0 next cycle. refill_done → plru_state=8'h16. Second refill → victim_way=8'h10 (idx 4).
- valid_mask=8'hFB with plru_state=8'h16, refill_req → victim_way=8'h04 (lowest invalid way wins over PLRU).
- From reset, hit_valid with hit_way=8'h20 (way 5) → plru_state=8'h08. A full-valid refill then → victim idx 0.
- In ALLOC with victim 0 from plru 0, same-cycle hit way 1 (8'h02) and refill_done → plru_state=8'h16 (node 4 taken from the victim touch) and victim_valid drops.
- In ALLOC with plru_state=8'h16, assert flush with refill_done → next cycle plru_state=0, busy=0, victim_way=0. A subsequent refill picks way 0.
- Assert rst_n low asynchronously mid-ALLOC → all outputs are at their reset values before the next clock edge. Hold refill_req high across ALLOC and check the victim stays latched while hits change plru_state.
